// File: rtl/diff_patch_decoder.sv
// diff_patch_decoder: rebuilds in2 from base (in1) and an
// ascending stream of differing-bit positions from the diff unit.
//
// Ports:
//   clk, rst        rising-edge clock, async active-low reset
//   start, equal    begin request (IDLE only); equal = no diffs
//   base            base word, captured on accepted start
//   idx_valid/idx/idx_last/idx_ready  position stream handshake
//   out, out_valid, out_ack           result, held until ack
//   cnt             number of bits flipped
//   err             sticky ordering error for this stream
//   busy            high in COLLECT and DONE
module diff_patch_decoder #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             equal,
   input  logic [WIDTH-1:0] base,
   input  logic             idx_valid,
   input  logic [IDXW-1:0]  idx,
   input  logic             idx_last,
   output logic             idx_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [IDXW:0]    cnt,
   output logic             err,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_acc,   w_acc_nx;
   logic [WIDTH-1:0] r_out,   w_out_nx;
   logic [IDXW:0]    r_cnt,   w_cnt_nx;
   logic             r_err,   w_err_nx;
   logic [IDXW-1:0]  r_prev,  w_prev_nx;
   logic             r_first, w_first_nx;
   logic             r_ov,    w_ov_nx;
   logic             r_busy,  w_busy_nx;

   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_acc_flip;
   logic             w_ok;

   assign w_mask     = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
   assign w_acc_flip = r_acc ^ w_mask;
   // Strictly increasing order; a duplicate never toggles back.
   assign w_ok       = r_first | (idx > r_prev);

   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_out_nx   = r_out;
      w_cnt_nx   = r_cnt;
      w_err_nx   = r_err;
      w_prev_nx  = r_prev;
      w_first_nx = r_first;
      w_ov_nx    = r_ov;
      w_busy_nx  = r_busy;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_cnt_nx  = '0;
               w_err_nx  = 1'b0;
               w_busy_nx = 1'b1;
               if (equal) begin
                  w_out_nx   = base;
                  w_ov_nx    = 1'b1;
                  w_state_nx = S_DONE;
               end else begin
                  w_acc_nx   = base;
                  w_first_nx = 1'b1;
                  w_state_nx = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (idx_valid) begin
               if (w_ok) begin
                  w_acc_nx   = w_acc_flip;
                  w_prev_nx  = idx;
                  w_cnt_nx   = r_cnt + 1'b1;
                  w_first_nx = 1'b0;
               end else begin
                  w_err_nx = 1'b1;
               end
               if (idx_last) begin
                  // Result includes the flip of this same beat.
                  w_out_nx   = w_ok ? w_acc_flip : r_acc;
                  w_ov_nx    = 1'b1;
                  w_state_nx = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ack) begin
               w_ov_nx    = 1'b0;
               w_busy_nx  = 1'b0;
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_ov_nx    = 1'b0;
            w_busy_nx  = 1'b0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_out   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_prev  <= '0;
         r_first <= 1'b0;
         r_ov    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_acc   <= w_acc_nx;
         r_out   <= w_out_nx;
         r_cnt   <= w_cnt_nx;
         r_err   <= w_err_nx;
         r_prev  <= w_prev_nx;
         r_first <= w_first_nx;
         r_ov    <= w_ov_nx;
         r_busy  <= w_busy_nx;
      end
   end

   assign idx_ready = (r_state == S_COLLECT);
   assign out       = r_out;
   assign out_valid = r_ov;
   assign cnt       = r_cnt;
   assign err       = r_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_diff_patch_decoder.sv
// tb_diff_patch_decoder: table vectors, corner sequences and
// random streams against a positional reference model.
module tb_diff_patch_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        equal = 1'b0;
   logic [31:0] base = '0;
   logic        idx_valid = 1'b0;
   logic [4:0]  idx = '0;
   logic        idx_last = 1'b0;
   logic        idx_ready;
   logic [31:0] out;
   logic        out_valid;
   logic        out_ack = 1'b0;
   logic [5:0]  cnt;
   logic        err;
   logic        busy;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   diff_patch_decoder #(.WIDTH(32), .IDXW(5)) dut (
      .clk(clk), .rst(rst), .start(start), .equal(equal),
      .base(base), .idx_valid(idx_valid), .idx(idx),
      .idx_last(idx_last), .idx_ready(idx_ready), .out(out),
      .out_valid(out_valid), .out_ack(out_ack), .cnt(cnt),
      .err(err), .busy(busy)
   );

   typedef struct packed {
      logic [31:0]     b;
      logic            eq;
      logic [3:0]      n;
      logic [7:0][4:0] ids;
      logic [31:0]     eo;
      logic [5:0]      ec;
      logic            ee;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: flip the bit at each position that rises above
   // every position seen before; anything else is an error.
   function automatic void model(input logic [31:0] b,
                                 input logic eq, input int n,
                                 input logic [31:0][4:0] ids,
                                 output logic [31:0] o,
                                 output logic [5:0] c,
                                 output logic e);
      int hi;
      o = b;
      c = 0;
      e = 1'b0;
      hi = -1;
      if (!eq) begin
         for (int i = 0; i < n; i++) begin
            if (int'(ids[i]) > hi) begin
               o[ids[i]] = ~o[ids[i]];
               c = c + 6'd1;
               hi = int'(ids[i]);
            end else begin
               e = 1'b1;
            end
         end
      end
   endfunction

   task automatic run(input logic [31:0] b, input logic eq,
                      input int n, input logic [31:0][4:0] ids,
                      input bit gaps, input logic [31:0] eo,
                      input logic [5:0] ec, input logic ee,
                      input bit do_ack);
      chk("idle_ready", {63'd0, idx_ready}, 64'd0);
      start = 1'b1;
      equal = eq;
      base  = b;
      tick();
      start = 1'b0;
      equal = 1'b0;
      if (eq) begin
         chk("eq_ready", {63'd0, idx_ready}, 64'd0);
      end else begin
         for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
               idx_valid = 1'b0;
               tick();
            end
            idx_valid = 1'b1;
            idx       = ids[i];
            idx_last  = (i == n - 1);
            chk("ready", {63'd0, idx_ready}, 64'd1);
            tick();
            idx_valid = 1'b0;
            idx_last  = 1'b0;
         end
      end
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out", {32'd0, out}, {32'd0, eo});
      chk("cnt", {58'd0, cnt}, {58'd0, ec});
      chk("err", {63'd0, err}, {63'd0, ee});
      chk("busy", {63'd0, busy}, 64'd1);
      if (do_ack) begin
         out_ack = 1'b1;
         tick();
         out_ack = 1'b0;
         chk("ack_valid", {63'd0, out_valid}, 64'd0);
         chk("ack_out", {32'd0, out}, {32'd0, eo});
         chk("ack_busy", {63'd0, busy}, 64'd0);
      end
   endtask

   initial begin
      logic [31:0][4:0] ids;
      logic [31:0] eo;
      logic [5:0]  ec;
      logic        ee;
      logic [31:0] b;
      logic        eq;
      int          n;
      int          cur;

      tbl[0] = '0;
      tbl[0].b = 32'h0000_00F0; tbl[0].n = 4'd3;
      tbl[0].ids[0] = 5'd0; tbl[0].ids[1] = 5'd3;
      tbl[0].ids[2] = 5'd31;
      tbl[0].eo = 32'h8000_00F9; tbl[0].ec = 6'd3;
      tbl[1] = '0;
      tbl[1].b = 32'hDEAD_BEEF; tbl[1].eq = 1'b1;
      tbl[1].eo = 32'hDEAD_BEEF;
      tbl[2] = '0;
      tbl[2].n = 4'd2;
      tbl[2].ids[0] = 5'd5; tbl[2].ids[1] = 5'd2;
      tbl[2].eo = 32'h0000_0020; tbl[2].ec = 6'd1;
      tbl[2].ee = 1'b1;
      tbl[3] = '0;
      tbl[3].b = 32'h0000_0001; tbl[3].n = 4'd2;
      tbl[3].ids[0] = 5'd1; tbl[3].ids[1] = 5'd2;
      tbl[3].eo = 32'h0000_0007; tbl[3].ec = 6'd2;
      tbl[4] = '0;
      tbl[4].n = 4'd2;
      tbl[4].ids[0] = 5'd7; tbl[4].ids[1] = 5'd7;
      tbl[4].eo = 32'h0000_0080; tbl[4].ec = 6'd1;
      tbl[4].ee = 1'b1;
      tbl[5] = '0;
      tbl[5].b = 32'h8000_0000; tbl[5].n = 4'd1;
      tbl[5].ids[0] = 5'd31;
      tbl[5].eo = 32'h0; tbl[5].ec = 6'd1;

      // Reset state
      #1;
      chk("rst_out", {32'd0, out}, 64'd0);
      chk("rst_cnt", {58'd0, cnt}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_ready", {63'd0, idx_ready}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      tick();
      rst = 1'b1;
      tick();

      for (int t = 0; t < 6; t++) begin
         ids = '0;
         for (int i = 0; i < 8; i++) ids[i] = tbl[t].ids[i];
         run(tbl[t].b, tbl[t].eq, int'(tbl[t].n), ids, 1'b0,
             tbl[t].eo, tbl[t].ec, tbl[t].ee, 1'b1);
         tick();
      end

      // Backpressure in DONE, then ack colliding with start
      ids = '0;
      ids[0] = 5'd0; ids[1] = 5'd3; ids[2] = 5'd31;
      run(32'h0000_00F0, 1'b0, 3, ids, 1'b0,
          32'h8000_00F9, 6'd3, 1'b0, 1'b0);
      idx_valid = 1'b1;
      idx = 5'd9;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_ready", {63'd0, idx_ready}, 64'd0);
         chk("bp_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_out", {32'd0, out}, 64'h8000_00F9);
         chk("bp_cnt", {58'd0, cnt}, 64'd3);
      end
      idx_valid = 1'b0;
      out_ack = 1'b1;
      start = 1'b1;
      base = 32'h1234_5678;
      tick();
      out_ack = 1'b0;
      start = 1'b0;
      chk("col_valid", {63'd0, out_valid}, 64'd0);
      chk("col_busy", {63'd0, busy}, 64'd0);
      tick();
      chk("col_idle", {63'd0, busy}, 64'd0);
      chk("col_ready", {63'd0, idx_ready}, 64'd0);
      chk("col_out", {32'd0, out}, 64'h8000_00F9);

      // Async reset mid-stream
      start = 1'b1;
      base = 32'hFFFF_FFFF;
      tick();
      start = 1'b0;
      idx_valid = 1'b1;
      idx = 5'd1;
      tick();
      idx_valid = 1'b0;
      chk("mid_cnt", {58'd0, cnt}, 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("ar_out", {32'd0, out}, 64'd0);
      chk("ar_cnt", {58'd0, cnt}, 64'd0);
      chk("ar_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_ready", {63'd0, idx_ready}, 64'd0);
      #1 rst = 1'b1;
      tick();
      ids = '0;
      ids[0] = 5'd4;
      run(32'hFFFF_FFFF, 1'b0, 1, ids, 1'b0,
          32'hFFFF_FFEF, 6'd1, 1'b0, 1'b1);

      // All 32 positions back to back
      for (int i = 0; i < 32; i++) ids[i] = 5'(i);
      run(32'h0, 1'b0, 32, ids, 1'b0,
          32'hFFFF_FFFF, 6'd32, 1'b0, 1'b1);

      // Random streams
      for (int r = 0; r < 60; r++) begin
         b  = $urandom;
         eq = ($urandom_range(0, 7) == 0);
         n  = $urandom_range(1, 10);
         cur = $urandom_range(0, 6);
         ids = '0;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0 || cur > 31) begin
               ids[i] = 5'($urandom_range(0, 31));
            end else begin
               ids[i] = 5'(cur);
               cur = cur + $urandom_range(1, 4);
            end
         end
         model(b, eq, n, ids, eo, ec, ee);
         run(b, eq, n, ids, 1'b1, eo, ec, ee, 1'b1);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
